// File: rtl/ntt_merge_pkg.sv
// rtl/ntt_merge_pkg.sv - shared mode encodings and group-count helper for the NTT merge stage
package ntt_merge_pkg;

    localparam logic [1:0] MODE_FULL = 2'd0;
    localparam logic [1:0] MODE_G1   = 2'd1;
    localparam logic [1:0] MODE_G2   = 2'd2;
    localparam logic [1:0] MODE_BAD  = 2'd3;

    localparam int SRC_MULT = 2;

    // A group length that spans every input lane degenerates to a single group.
    function automatic int ng(input int len, input int size);
        if (len >= size - 1)
            return 1;
        else
            return (size - 2) / len;
    endfunction

endpackage

// File: rtl/merge_lane_map.sv
// rtl/merge_lane_map.sv - combinational lane routing for one group length
module merge_lane_map
    import ntt_merge_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int SIZE     = 257,
    parameter int N_ADDERS = 51,
    parameter int LEN      = 17
) (
    input  logic [(SIZE-1)*WIDTH-1:0] src,
    input  logic [N_ADDERS*WIDTH-1:0] adders,
    input  logic [N_ADDERS*WIDTH-1:0] prev,
    input  logic                      use_prev,
    output logic [SIZE*WIDTH-1:0]     lanes
);

    localparam int NG = ng(LEN, SIZE);

    // Routing is fixed at elaboration; only the source/prev choice is dynamic.
    for (genvar e = 0; e < SIZE; e++) begin : g_lane
        localparam int G = e / LEN;
        localparam int J = e % LEN;
        if (e < NG * LEN) begin : g_grp
            if (J == 0) begin : g_head
                assign lanes[e*WIDTH +: WIDTH] = use_prev ? prev[G*WIDTH +: WIDTH]
                                                          : adders[G*WIDTH +: WIDTH];
            end else if (J == 1) begin : g_second
                assign lanes[e*WIDTH +: WIDTH] = use_prev ? adders[G*WIDTH +: WIDTH]
                                                          : src[(G*(LEN-1))*WIDTH +: WIDTH];
            end else begin : g_body
                assign lanes[e*WIDTH +: WIDTH] = src[(G*(LEN-1)+J-1)*WIDTH +: WIDTH];
            end
        end else if (e == 0) begin : g_dflt0
            assign lanes[e*WIDTH +: WIDTH] = adders[0 +: WIDTH];
        end else begin : g_dflt
            assign lanes[e*WIDTH +: WIDTH] = src[(e-1)*WIDTH +: WIDTH];
        end
    end

    // Not every lane of every input is routed for every length.
    logic unused_bits;
    assign unused_bits = ^{src, adders, prev};

endmodule

// File: rtl/merger_pipelined.sv
// rtl/merger_pipelined.sv - registered merge stage interleaving butterfly/multiplier and adder lanes
module merger_pipelined
    import ntt_merge_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int SIZE     = 257,
    parameter int N_ADDERS = 51,
    parameter int GRP_L0   = 257,
    parameter int GRP_L1   = 17,
    parameter int GRP_L2   = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [(SIZE-1)*WIDTH-1:0] bfa_out,
    input  logic [(SIZE-1)*WIDTH-1:0] mult_out,
    input  logic [N_ADDERS*WIDTH-1:0] adder_result,
    input  logic [2:0]                merge_sel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SIZE*WIDTH-1:0]     output_list,
    output logic                      prev_missing,
    output logic                      mode_err
);

    logic [N_ADDERS*WIDTH-1:0] hist;
    logic                      hist_vld;
    logic [1:0]                last_len;

    logic                      acc;
    logic [1:0]                len_sel;
    logic                      use_mult;
    logic                      hist_eff;
    logic [(SIZE-1)*WIDTH-1:0] src;
    logic [N_ADDERS*WIDTH-1:0] prev_sel;
    logic [SIZE*WIDTH-1:0]     lanes0, lanes1, lanes2, merged;

    assign in_ready = !out_valid || out_ready;
    assign acc      = in_valid && in_ready;
    assign len_sel  = merge_sel[1:0];
    assign use_mult = merge_sel[SRC_MULT];
    assign src      = use_mult ? mult_out : bfa_out;

    // History from a different group length is meaningless to this beat.
    assign hist_eff = hist_vld && (len_sel == last_len);
    assign prev_sel = hist_eff ? hist : '0;

    merge_lane_map #(.WIDTH(WIDTH), .SIZE(SIZE), .N_ADDERS(N_ADDERS), .LEN(GRP_L0)) u_map0 (
        .src(src), .adders(adder_result), .prev(prev_sel), .use_prev(use_mult), .lanes(lanes0)
    );
    merge_lane_map #(.WIDTH(WIDTH), .SIZE(SIZE), .N_ADDERS(N_ADDERS), .LEN(GRP_L1)) u_map1 (
        .src(src), .adders(adder_result), .prev(prev_sel), .use_prev(use_mult), .lanes(lanes1)
    );
    merge_lane_map #(.WIDTH(WIDTH), .SIZE(SIZE), .N_ADDERS(N_ADDERS), .LEN(GRP_L2)) u_map2 (
        .src(src), .adders(adder_result), .prev(prev_sel), .use_prev(use_mult), .lanes(lanes2)
    );

    always_comb begin
        merged = lanes0;
        case (len_sel)
            MODE_G1: merged = lanes1;
            MODE_G2: merged = lanes2;
            default: merged = lanes0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            output_list  <= '0;
            prev_missing <= 1'b0;
            mode_err     <= 1'b0;
            hist         <= '0;
            hist_vld     <= 1'b0;
            last_len     <= 2'd0;
        end else begin
            if (acc) begin
                out_valid    <= 1'b1;
                output_list  <= merged;
                prev_missing <= use_mult && !hist_eff;
                hist         <= adder_result;
                hist_vld     <= 1'b1;
                last_len     <= len_sel;
                if (len_sel == MODE_BAD)
                    mode_err <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_merger_pipelined.sv
// tb/tb_merger_pipelined.sv - randomized self-checking bench for merger_pipelined
module tb_merger_pipelined;

    localparam int W  = 32;
    localparam int SZ = 257;
    localparam int NA = 51;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst, in_valid, in_ready, out_valid, out_ready;
    logic                  prev_missing, mode_err;
    logic [(SZ-1)*W-1:0]   bfa_out, mult_out;
    logic [NA*W-1:0]       adder_result;
    logic [2:0]            merge_sel;
    logic [SZ*W-1:0]       output_list;

    merger_pipelined dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .bfa_out(bfa_out), .mult_out(mult_out), .adder_result(adder_result),
        .merge_sel(merge_sel), .out_valid(out_valid), .out_ready(out_ready),
        .output_list(output_list), .prev_missing(prev_missing), .mode_err(mode_err)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] bfa_a[SZ-1];
    logic [31:0] mult_a[SZ-1];
    logic [31:0] add_a[NA];

    logic [31:0] m_hist[NA];
    bit          m_vld;
    logic [1:0]  m_last;
    bit          m_err;

    logic [31:0]   exp_lane[SZ];
    logic [SZ*W-1:0] exp_flat;
    bit            exp_pm;
    logic [SZ*W-1:0] held;

    task automatic model_reset();
        for (int g = 0; g < NA; g++) m_hist[g] = '0;
        m_vld = 0; m_last = 2'd0; m_err = 0;
    endtask

    task automatic model_expect(input logic [2:0] sel);
        int k, len, ngk, e, s;
        bit mult, eff;
        k    = (sel[1:0] == 2'd3) ? 0 : int'(sel[1:0]);
        len  = (k == 0) ? 257 : (k == 1) ? 17 : 5;
        ngk  = (k == 0) ? 1 : (SZ - 2) / len;
        mult = sel[2];
        eff  = m_vld && (sel[1:0] == m_last);
        for (int i = 0; i < SZ; i++)
            exp_lane[i] = (i == 0) ? add_a[0] : (mult ? mult_a[i-1] : bfa_a[i-1]);
        for (int g = 0; g < ngk; g++) begin
            for (int j = 0; j < len; j++) begin
                e = g * len + j;
                s = g * (len - 1) + j - 1;
                if (!mult) begin
                    if (j == 0) exp_lane[e] = add_a[g];
                    else        exp_lane[e] = bfa_a[s];
                end else begin
                    if (j == 0)      exp_lane[e] = eff ? m_hist[g] : 32'd0;
                    else if (j == 1) exp_lane[e] = add_a[g];
                    else             exp_lane[e] = mult_a[s];
                end
            end
        end
        exp_pm = mult && !eff;
        for (int i = 0; i < SZ; i++) exp_flat[i*W +: W] = exp_lane[i];
    endtask

    task automatic model_commit(input logic [2:0] sel);
        for (int g = 0; g < NA; g++) m_hist[g] = add_a[g];
        m_vld  = 1;
        m_last = sel[1:0];
        if (sel[1:0] == 2'd3) m_err = 1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < SZ - 1; i++) begin
            bfa_a[i]  = $urandom;
            mult_a[i] = $urandom;
        end
        for (int g = 0; g < NA; g++) add_a[g] = $urandom;
    endtask

    task automatic drive_beat(input logic [2:0] sel);
        for (int i = 0; i < SZ - 1; i++) begin
            bfa_out[i*W +: W]  = bfa_a[i];
            mult_out[i*W +: W] = mult_a[i];
        end
        for (int g = 0; g < NA; g++) adder_result[g*W +: W] = add_a[g];
        merge_sel = sel;
        in_valid  = 1'b1;
        model_expect(sel);
    endtask

    task automatic send_beat(input logic [2:0] sel);
        drive_beat(sel);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_commit(sel);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    function automatic int first_diff(input logic [SZ*W-1:0] want);
        for (int i = 0; i < SZ; i++)
            if (output_list[i*W +: W] !== want[i*W +: W]) return i;
        return 0;
    endfunction

    function automatic logic [31:0] lane(input int i);
        return output_list[i*W +: W];
    endfunction

    task automatic test_reset();
        int d;
        do_reset();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        total++; if (output_list !== '0) begin bad++; d = first_diff('0); $display("FAIL reset_output lane %0d got %h exp 0", d, lane(d)); end
        total++; if (prev_missing !== 1'b0) begin bad++; $display("FAIL reset_prev_missing got %b exp 0", prev_missing); end
        total++; if (mode_err !== 1'b0) begin bad++; $display("FAIL reset_mode_err got %b exp 0", mode_err); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_mode0();
        int d;
        rand_data();
        for (int i = 0; i < SZ - 1; i++) bfa_a[i] = i + 1;
        add_a[0] = 32'hAAAA;
        send_beat(3'd0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL m0_out_valid got %b exp 1", out_valid); end
        total++; if (output_list !== exp_flat) begin bad++; d = first_diff(exp_flat); $display("FAIL m0_output lane %0d got %h exp %h", d, lane(d), exp_lane[d]); end
        total++; if (lane(0) !== 32'hAAAA) begin bad++; $display("FAIL m0_lane0 got %h exp aaaa", lane(0)); end
        total++; if (lane(256) !== 32'd256) begin bad++; $display("FAIL m0_lane256 got %h exp 100", lane(256)); end
    endtask

    task automatic test_mode1();
        int d;
        rand_data();
        for (int i = 0; i < SZ - 1; i++) bfa_a[i] = i;
        for (int g = 0; g < NA; g++) add_a[g] = 32'h100 + g;
        send_beat(3'd1);
        total++; if (output_list !== exp_flat) begin bad++; d = first_diff(exp_flat); $display("FAIL m1_output lane %0d got %h exp %h", d, lane(d), exp_lane[d]); end
        total++; if (lane(51) !== 32'h103) begin bad++; $display("FAIL m1_lane51 got %h exp 103", lane(51)); end
        total++; if (lane(52) !== 32'd48) begin bad++; $display("FAIL m1_lane52 got %h exp 30", lane(52)); end
        total++; if (lane(256) !== 32'd255) begin bad++; $display("FAIL m1_lane256 got %h exp ff", lane(256)); end
        total++; if (prev_missing !== 1'b0) begin bad++; $display("FAIL m1_prev_missing got %b exp 0", prev_missing); end
    endtask

    task automatic test_mult_history();
        int d;
        do_reset();
        rand_data();
        for (int g = 0; g < NA; g++) add_a[g] = 32'h200 + g;
        send_beat(3'd6);
        total++; if (prev_missing !== 1'b1) begin bad++; $display("FAIL hist1_prev_missing got %b exp 1", prev_missing); end
        total++; if (lane(36) !== 32'h207) begin bad++; $display("FAIL hist1_lane36 got %h exp 207", lane(36)); end
        total++; if (lane(35) !== 32'h0) begin bad++; $display("FAIL hist1_lane35 got %h exp 0", lane(35)); end
        total++; if (output_list !== exp_flat) begin bad++; d = first_diff(exp_flat); $display("FAIL hist1_output lane %0d got %h exp %h", d, lane(d), exp_lane[d]); end
        rand_data();
        for (int g = 0; g < NA; g++) add_a[g] = 32'h300 + g;
        send_beat(3'd6);
        total++; if (prev_missing !== 1'b0) begin bad++; $display("FAIL hist2_prev_missing got %b exp 0", prev_missing); end
        total++; if (lane(35) !== 32'h207) begin bad++; $display("FAIL hist2_lane35 got %h exp 207", lane(35)); end
        total++; if (output_list !== exp_flat) begin bad++; d = first_diff(exp_flat); $display("FAIL hist2_output lane %0d got %h exp %h", d, lane(d), exp_lane[d]); end
    endtask

    task automatic test_backpressure();
        int d;
        out_ready = 1'b1;
        rand_data();
        send_beat(3'd2);
        held = exp_flat;
        out_ready = 1'b0;
        rand_data();
        drive_beat(3'd5);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cycle %0d got %b exp 0", c, in_ready); end
            total++; if (out_valid !== 1'b1 || output_list !== held) begin
                bad++; d = first_diff(held);
                $display("FAIL bp_hold cycle %0d valid %b lane %0d got %h exp %h", c, out_valid, d, lane(d), held[d*W +: W]);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_commit(3'd5);
        total++; if (out_valid !== 1'b1 || output_list !== exp_flat) begin
            bad++; d = first_diff(exp_flat);
            $display("FAIL bp_queued valid %b lane %0d got %h exp %h", out_valid, d, lane(d), exp_lane[d]);
        end
        @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_len_change();
        int d;
        rand_data();
        send_beat(3'd5);
        rand_data();
        send_beat(3'd6);
        total++; if (prev_missing !== 1'b1) begin bad++; $display("FAIL lc_prev_missing got %b exp 1", prev_missing); end
        total++; if (lane(0) !== 32'h0 || lane(5) !== 32'h0) begin bad++; $display("FAIL lc_p_slots got %h %h exp 0 0", lane(0), lane(5)); end
        total++; if (output_list !== exp_flat) begin bad++; d = first_diff(exp_flat); $display("FAIL lc_output lane %0d got %h exp %h", d, lane(d), exp_lane[d]); end
    endtask

    task automatic test_mode_err();
        int d;
        rand_data();
        send_beat(3'd3);
        total++; if (mode_err !== 1'b1) begin bad++; $display("FAIL err_set got %b exp 1", mode_err); end
        total++; if (output_list !== exp_flat) begin bad++; d = first_diff(exp_flat); $display("FAIL err_layout lane %0d got %h exp %h", d, lane(d), exp_lane[d]); end
        rand_data();
        send_beat(3'd1);
        total++; if (mode_err !== 1'b1) begin bad++; $display("FAIL err_sticky got %b exp 1", mode_err); end
        do_reset();
        total++; if (mode_err !== 1'b0) begin bad++; $display("FAIL err_rst got %b exp 0", mode_err); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL err_rst_valid got %b exp 0", out_valid); end
        rand_data();
        send_beat(3'd4);
        total++; if (prev_missing !== 1'b1) begin bad++; $display("FAIL rst_hist_cleared got %b exp 1", prev_missing); end
        total++; if (output_list !== exp_flat) begin bad++; d = first_diff(exp_flat); $display("FAIL rst_mult_out lane %0d got %h exp %h", d, lane(d), exp_lane[d]); end
    endtask

    task automatic test_random();
        logic [2:0] sels[6];
        logic [2:0] s;
        int d;
        sels[0] = 3'd0; sels[1] = 3'd1; sels[2] = 3'd2;
        sels[3] = 3'd4; sels[4] = 3'd5; sels[5] = 3'd6;
        for (int n = 0; n < 30; n++) begin
            s = sels[$urandom_range(5, 0)];
            rand_data();
            send_beat(s);
            total++; if (output_list !== exp_flat || prev_missing !== exp_pm) begin
                bad++; d = first_diff(exp_flat);
                $display("FAIL rnd%0d sel %0d lane %0d got %h exp %h pm %b exp %b", n, s, d, lane(d), exp_lane[d], prev_missing, exp_pm);
            end
            if ($urandom_range(3, 0) == 0) begin
                @(posedge clk);
                #1;
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rnd%0d_idle got %b exp 0", n, out_valid); end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        merge_sel = 3'd0;
        bfa_out = '0;
        mult_out = '0;
        adder_result = '0;
        model_reset();
        test_reset();
        test_mode0();
        test_mode1();
        test_mult_history();
        test_backpressure();
        test_len_change();
        test_mode_err();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
